fft8_out_serializer: RTL and testbench

- Sits directly downstream of the 8-point FFT core.
- Captures one parallel frame of 8 complex bins (16 signed words) on a single-cycle frame strobe.
- Streams the bins out one per cycle, bin 0 first, over a valid/ready interface to the consumer (UART/DMA packer or magnitude stage).
- Double-buffered so the core can deliver the next frame while the current one is still streaming; frames that cannot be held are dropped and flagged.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_frame_buf.sv | 44 ++++
 rtl/fft8_out_serializer.sv | 156 +++++++++++++++
 tb/tb_fft8_out_serializer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants and serializer state encoding
package fft_pkg;

  localparam int FFT_W      = 16;
  localparam int FFT_N      = 8;
  localparam int FFT_IDX_W  = $clog2(FFT_N);
  localparam int FFT_Q_FRAC = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - one frame of N complex bins with whole-frame load and per-bin read mux
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int  W     = FFT_W,
  parameter int  N     = FFT_N,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [N*W-1:0]   ld_real,
  input  logic [N*W-1:0]   ld_imag,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_real,
  output logic [W-1:0]     rd_imag
);

  logic [N*W-1:0] real_q, real_d;
  logic [N*W-1:0] imag_q, imag_d;

  always_comb begin
    real_d = real_q;
    imag_d = imag_q;
    if (ld) begin
      real_d = ld_real;
      imag_d = ld_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_q <= '0;
      imag_q <= '0;
    end else begin
      real_q <= real_d;
      imag_q <= imag_d;
    end
  end

  assign rd_real = real_q[int'(rd_idx)*W +: W];
  assign rd_imag = imag_q[int'(rd_idx)*W +: W];

endmodule

// File: rtl/fft8_out_serializer.sv
// rtl/fft8_out_serializer.sv - double-buffered parallel-frame to valid/ready bin stream
module fft8_out_serializer
  import fft_pkg::*;
#(
  parameter int  W     = FFT_W,
  parameter int  N     = FFT_N,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_stb,
  input  logic [N*W-1:0]   in_real,
  input  logic [N*W-1:0]   in_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_real,
  output logic [W-1:0]     out_imag,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic             ovf_q, ovf_d;
  logic             act_sel_q, act_sel_d;
  logic [W-1:0]     out_real_q, out_real_d;
  logic [W-1:0]     out_imag_q, out_imag_d;

  logic             hs;
  logic             frame_end;
  logic             ld_en;
  logic             ld_tgt;
  logic             act_from_in;
  logic [W-1:0]     b0_rd_real, b0_rd_imag, b1_rd_real, b1_rd_imag;

  assign hs        = (state_q == ST_STREAM) && out_ready;
  assign frame_end = hs && (cnt_q == LAST_IDX);

  // ACT/PEND are roles of two physical buffers; promoting PEND is a pointer flip.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    act_sel_d   = act_sel_q;
    ovf_d       = ovf_q & ~ovf_clr;
    ld_en       = 1'b0;
    ld_tgt      = act_sel_q;
    act_from_in = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_stb) begin
          ld_en       = 1'b1;
          act_from_in = 1'b1;
          cnt_d       = '0;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (frame_end) begin
          cnt_d = '0;
          if (pend_v_q) begin
            act_sel_d = ~act_sel_q;
            pend_v_d  = in_stb;
            ld_en     = in_stb;
          end else if (in_stb) begin
            ld_en       = 1'b1;
            act_from_in = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (hs) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_stb) begin
            if (!pend_v_q) begin
              ld_en    = 1'b1;
              ld_tgt   = ~act_sel_q;
              pend_v_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A freshly loaded ACT is not yet in its buffer, so bin 0 bypasses from the input.
  always_comb begin
    out_real_d = act_sel_d ? b1_rd_real : b0_rd_real;
    out_imag_d = act_sel_d ? b1_rd_imag : b0_rd_imag;
    if (act_from_in) begin
      out_real_d = in_real[W-1:0];
      out_imag_d = in_imag[W-1:0];
    end
  end

  fft_frame_buf #(.W(W), .N(N)) u_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld_en && !ld_tgt),
    .ld_real (in_real),
    .ld_imag (in_imag),
    .rd_idx  (cnt_d),
    .rd_real (b0_rd_real),
    .rd_imag (b0_rd_imag)
  );

  fft_frame_buf #(.W(W), .N(N)) u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld_en && ld_tgt),
    .ld_real (in_real),
    .ld_imag (in_imag),
    .rd_idx  (cnt_d),
    .rd_real (b1_rd_real),
    .rd_imag (b1_rd_imag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      ovf_q      <= 1'b0;
      act_sel_q  <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      ovf_q      <= ovf_d;
      act_sel_q  <= act_sel_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  assign out_valid = (state_q == ST_STREAM);
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_idx   = cnt_q;
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign busy      = out_valid | pend_v_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fft8_out_serializer.sv
// tb/tb_fft8_out_serializer.sv - scoreboard bench for the FFT output serializer
module tb_fft8_out_serializer;
  import fft_pkg::*;

  localparam int W  = FFT_W;
  localparam int N  = FFT_N;
  localparam int IW = FFT_IDX_W;

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [IW-1:0] idx;
  } word_t;

  logic           clk;
  logic           rst_n;
  logic           in_stb;
  logic [N*W-1:0] in_real;
  logic [N*W-1:0] in_imag;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_real;
  logic [W-1:0]   out_imag;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           overflow;
  logic           ovf_clr;

  word_t exp_q[$];
  int    checks;
  int    failures;

  fft8_out_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_stb    (in_stb),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_frame(input int kind, input int tag);
    logic [W-1:0] re;
    logic [W-1:0] im;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: begin re = W'(k << FFT_Q_FRAC); im = W'(-(k << FFT_Q_FRAC)); end
        1: begin re = W'(tag); im = W'(tag); end
        default: begin re = W'(tag * 16 + k); im = ~re; end
      endcase
      in_real[k*W +: W] = re;
      in_imag[k*W +: W] = im;
    end
  endtask

  task automatic push_frame();
    word_t w;
    for (int k = 0; k < N; k++) begin
      w.re  = in_real[k*W +: W];
      w.im  = in_imag[k*W +: W];
      w.idx = IW'(k);
      exp_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_stb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    in_real = '0; in_imag = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got v/l/b/o=%b%b%b%b required 0000", out_valid, out_last, busy, overflow);
    end
    checks++;
    if (out_real !== '0 || out_imag !== '0 || out_idx !== '0) begin
      failures++;
      $display("FAIL reset_data got re=%h im=%h idx=%0d required 0/0/0", out_real, out_imag, out_idx);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_basic();
    word_t e;
    int    hs = 0;
    load_frame(0, 0);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      in_stb = (c == 0); out_ready = 1'b1;
      if (c == 0) push_frame();
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL basic_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL basic_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++; $display("FAIL basic_latency cycle=%0d got valid=%b required 1", c, out_valid);
        end
      end
      if (c == 9) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL basic_tail got valid=%b busy=%b required 0 0", out_valid, busy);
        end
      end
    end
    checks++;
    if (hs != 8 || exp_q.size() != 0) begin
      failures++; $display("FAIL basic_count got hs=%0d left=%0d required 8 0", hs, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    word_t e;
    int    hs = 0;
    logic  stall = 1'b0;
    logic [2*W+IW+1:0] saved = '0;
    load_frame(0, 0);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      in_stb = (c == 0); out_ready = (c % 3 == 0);
      if (c == 0) push_frame();
      if (stall) begin
        checks++;
        if ({out_valid, out_real, out_imag, out_idx, out_last} !== saved) begin
          failures++;
          $display("FAIL bp_hold got %h required %h", {out_valid, out_real, out_imag, out_idx, out_last}, saved);
        end
      end
      stall = out_valid && !out_ready;
      saved = {out_valid, out_real, out_imag, out_idx, out_last};
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL bp_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
    end
    checks++;
    if (hs != 8 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_count got hs=%0d left=%0d required 8 0", hs, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    word_t e;
    int    hs = 0;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_stb = (c == 0 || c == 3);
      if (c == 0) begin load_frame(1, 16'h0100); push_frame(); end
      if (c == 3) begin load_frame(1, 16'h0200); push_frame(); end
      if (c >= 1 && c <= 16) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++; $display("FAIL b2b_bubble cycle=%0d got valid=%b required 1", c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL b2b_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
    end
    checks++;
    if (hs != 16 || exp_q.size() != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count got hs=%0d left=%0d ovf=%b required 16 0 0", hs, exp_q.size(), overflow);
    end
  endtask

  task automatic test_overflow();
    word_t e;
    int    hs = 0;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      out_ready = (c >= 6);
      in_stb = (c <= 2);
      ovf_clr = (c == 23);
      if (c <= 2) begin
        load_frame(2, c + 1);
        if (c <= 1) push_frame();
      end
      if (c == 4) begin
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
          failures++; $display("FAIL ovf_set got ovf=%b busy=%b required 1 1", overflow, busy);
        end
      end
      if (c == 23) begin
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
          failures++; $display("FAIL ovf_sticky got ovf=%b valid=%b required 1 0", overflow, out_valid);
        end
      end
      if (c == 24) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_clear got ovf=%b required 0", overflow);
        end
      end
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ovf_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL ovf_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
    end
    ovf_clr = 1'b0;
    checks++;
    if (hs != 16 || exp_q.size() != 0) begin
      failures++; $display("FAIL ovf_count got hs=%0d left=%0d required 16 0", hs, exp_q.size());
    end
  endtask

  task automatic test_simul_end();
    word_t e;
    int    hs = 0;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_stb = (c == 0 || c == 2 || c == 8);
      if (in_stb) begin load_frame(2, 4 + c); push_frame(); end
      if (c >= 1 && c <= 24) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++; $display("FAIL simul_bubble cycle=%0d got valid=%b required 1", c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL simul_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL simul_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
    end
    checks++;
    if (hs != 24 || exp_q.size() != 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL simul_count got hs=%0d left=%0d ovf=%b required 24 0 0", hs, exp_q.size(), overflow);
    end
  endtask

  task automatic test_reset_mid();
    word_t e;
    int    hs = 0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_stb = (c <= 2);
      if (c <= 2) begin load_frame(2, 10 + c); if (c == 0) push_frame(); end
      if (out_valid && out_ready) begin
        hs++; checks++;
        e = exp_q.pop_front();
        if ({out_real, out_imag, out_idx} !== e) begin
          failures++;
          $display("FAIL rmid_word got re=%h im=%h idx=%0d required re=%h im=%h idx=%0d",
                   out_real, out_imag, out_idx, e.re, e.im, e.idx);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (out_idx !== IW'(3) || overflow !== 1'b1) begin
      failures++; $display("FAIL rmid_pre got idx=%0d ovf=%b required 3 1", out_idx, overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, overflow, out_last} !== 4'b0000 || out_real !== '0 || out_imag !== '0) begin
      failures++;
      $display("FAIL rmid_async got v/b/o/l=%b%b%b%b re=%h im=%h required 0000 0 0",
               out_valid, busy, overflow, out_last, out_real, out_imag);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL rmid_quiet cycle=%0d got valid=%b busy=%b required 0 0", c, out_valid, busy);
      end
    end
    hs = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      in_stb = (c == 0);
      if (c == 0) begin load_frame(2, 20); push_frame(); end
      if (out_valid && out_ready) begin
        hs++; checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rmid_word got unexpected idx=%0d required no word", out_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_real, out_imag, out_idx} !== e || out_last !== (e.idx == IW'(N-1))) begin
            failures++;
            $display("FAIL rmid_word got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d",
                     out_real, out_imag, out_idx, out_last, e.re, e.im, e.idx);
          end
        end
      end
    end
    checks++;
    if (hs != 8 || exp_q.size() != 0) begin
      failures++; $display("FAIL rmid_count got hs=%0d left=%0d required 8 0", hs, exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_simul_end();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
